// File: rtl/mult_div_sequencer_pkg.sv
// Shared encodings for the mult/div sequencer and the main control unit.
//   md_state_t  : sequencer state encodings
//   md_strobe_t : mult/div datapath strobe encodings
//   OP_MULT/DIV : operation select encodings
//   md_ctrl_t   : bundle of sequencer control outputs
package mult_div_sequencer_pkg;

    localparam int unsigned MD_ITERATIONS_DEF = 32;
    localparam int unsigned MD_COUNT_W_DEF    = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_FINISH = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_DIVZ   = 3'd6
    } md_state_t;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_LOAD   = 2'b01,
        MD_STEP   = 2'b10,
        MD_FINISH = 2'b11
    } md_strobe_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef struct packed {
        logic       temp_write;
        md_strobe_t mult;
        md_strobe_t div;
        logic       div_or_mult;
        logic       write_hi;
        logic       write_lo;
        logic       busy;
        logic       done;
        logic       div_zero;
    } md_ctrl_t;

endpackage

// File: rtl/md_iter_counter.sv
// Iteration counter for the mult/div sequencer.
//   Clock      : system clock
//   Reset      : synchronous active-high reset
//   clear      : load zero (takes priority over inc)
//   inc        : increment by one
//   terminal_c : count equals ITERATIONS-1 (combinational from the count register)
module md_iter_counter #(
    parameter int unsigned ITERATIONS = 32,
    parameter int unsigned COUNT_W    = 6
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic inc,
    output logic terminal_c
);

    logic [COUNT_W-1:0] count_q;

    // Count register; the final RUN increment reaches ITERATIONS, which still fits COUNT_W.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign terminal_c = (count_q == COUNT_W'(ITERATIONS - 1));

endmodule

// File: rtl/mult_div_sequencer.sv
// Multicycle sequencer for the shared iterative multiplier/divider.
//   Clock, Reset     : clock, synchronous active-high reset
//   Start/Op/DivisorZero : request, op select (0 mult / 1 div), B==0 flag; sampled in IDLE
//   DivMultTempWrite : capture operands into temp registers
//   Mult/Div         : datapath strobes (00 idle, 01 load, 10 step, 11 finish)
//   DivorMult        : Hi/Lo source select
//   WriteHi/WriteLo  : Hi/Lo write enables
//   Busy/Done/DivZero: status, completion pulse, divide-by-zero pulse
// Outputs are registered, decoded from the next state so they line up with the state register.
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int unsigned ITERATIONS = MD_ITERATIONS_DEF,
    parameter int unsigned COUNT_W    = MD_COUNT_W_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Op,
    input  logic       DivisorZero,
    output logic       DivMultTempWrite,
    output logic [1:0] Mult,
    output logic [1:0] Div,
    output logic       DivorMult,
    output logic       WriteHi,
    output logic       WriteLo,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);

    md_state_t  state_q, state_d;
    logic       op_q, op_d;
    md_ctrl_t   ctrl_q, ctrl_d;
    md_strobe_t strobe_c;
    logic       cnt_clear_c;
    logic       cnt_inc_c;
    logic       cnt_terminal_c;

    md_iter_counter #(
        .ITERATIONS (ITERATIONS),
        .COUNT_W    (COUNT_W)
    ) u_iter_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear      (cnt_clear_c),
        .inc        (cnt_inc_c),
        .terminal_c (cnt_terminal_c)
    );

    // State, latched op and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state, counter control, and output decode of the next state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ctrl_d      = '0;
        strobe_c    = MD_IDLE;
        cnt_clear_c = 1'b0;
        cnt_inc_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Op == OP_DIV && DivisorZero) begin
                        state_d = ST_DIVZ;
                    end else begin
                        state_d = ST_LOAD;
                        op_d    = Op;
                    end
                end
            end
            ST_LOAD: begin
                cnt_clear_c = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                cnt_inc_c = 1'b1;
                if (cnt_terminal_c) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_DIVZ:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_LOAD: begin
                ctrl_d.temp_write  = 1'b1;
                ctrl_d.div_or_mult = op_d;
                ctrl_d.busy        = 1'b1;
                strobe_c           = MD_LOAD;
            end
            ST_RUN: begin
                ctrl_d.div_or_mult = op_d;
                ctrl_d.busy        = 1'b1;
                strobe_c           = MD_STEP;
            end
            ST_FINISH: begin
                ctrl_d.div_or_mult = op_d;
                ctrl_d.busy        = 1'b1;
                strobe_c           = MD_FINISH;
            end
            ST_WRITE: begin
                ctrl_d.div_or_mult = op_d;
                ctrl_d.write_hi    = 1'b1;
                ctrl_d.write_lo    = 1'b1;
                ctrl_d.busy        = 1'b1;
            end
            ST_DONE: begin
                ctrl_d.busy = 1'b1;
                ctrl_d.done = 1'b1;
            end
            ST_DIVZ: begin
                ctrl_d.busy     = 1'b1;
                ctrl_d.div_zero = 1'b1;
            end
            default: ;
        endcase

        // Only the strobe of the latched op is driven; the other stays idle.
        if (op_d == OP_DIV) begin
            ctrl_d.div = strobe_c;
        end else begin
            ctrl_d.mult = strobe_c;
        end
    end

    assign DivMultTempWrite = ctrl_q.temp_write;
    assign Mult             = ctrl_q.mult;
    assign Div              = ctrl_q.div;
    assign DivorMult        = ctrl_q.div_or_mult;
    assign WriteHi          = ctrl_q.write_hi;
    assign WriteLo          = ctrl_q.write_lo;
    assign Busy             = ctrl_q.busy;
    assign Done             = ctrl_q.done;
    assign DivZero          = ctrl_q.div_zero;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: directed scenarios plus random traffic, every cycle
// compared against a cycle-offset model of an operation's timeline.
module tb_mult_div_sequencer;

    localparam int ITER = 32;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Op;
    logic       DivisorZero;
    logic       DivMultTempWrite;
    logic [1:0] Mult;
    logic [1:0] Div;
    logic       DivorMult;
    logic       WriteHi;
    logic       WriteLo;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    mult_div_sequencer dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Start            (Start),
        .Op               (Op),
        .DivisorZero      (DivisorZero),
        .DivMultTempWrite (DivMultTempWrite),
        .Mult             (Mult),
        .Div              (Div),
        .DivorMult        (DivorMult),
        .WriteHi          (WriteHi),
        .WriteLo          (WriteLo),
        .Busy             (Busy),
        .Done             (Done),
        .DivZero          (DivZero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: phase 0 = idle, -1 = divide-by-zero cycle, 1..ITER+4 = offset since Start accepted.
    int   phase = 0;
    logic mop   = 1'b0;

    int done_cnt, wr_cnt, divz_cnt, mstep_cnt, dstep_cnt;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [10:0] exp_outs(input int ph, input logic op);
        logic       tw, dm, wh, bz, dn, dz;
        logic [1:0] stb, m, d;
        tw = 0; dm = 0; wh = 0; bz = 0; dn = 0; dz = 0; stb = 2'b00; m = 2'b00; d = 2'b00;
        if (ph == -1) begin
            bz = 1; dz = 1;
        end else if (ph > 0) begin
            bz = 1;
            tw = (ph == 1);
            if (ph == 1)              stb = 2'b01;
            else if (ph <= ITER + 1)  stb = 2'b10;
            else if (ph == ITER + 2)  stb = 2'b11;
            dm = (ph <= ITER + 3) ? op : 1'b0;
            wh = (ph == ITER + 3);
            dn = (ph == ITER + 4);
            if (op) d = stb; else m = stb;
        end
        return {tw, m, d, dm, wh, wh, bz, dn, dz};
    endfunction

    task automatic clear_counts();
        done_cnt = 0; wr_cnt = 0; divz_cnt = 0; mstep_cnt = 0; dstep_cnt = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare all outputs.
    task automatic step(input logic s, input logic o, input logic dzi, input logic r);
        logic [10:0] got;
        Start = s; Op = o; DivisorZero = dzi; Reset = r;
        @(posedge Clock);
        cyc++;
        if (r) begin
            phase = 0; mop = 1'b0;
        end else if (phase == 0) begin
            if (s) begin
                if (o && dzi) phase = -1;
                else begin phase = 1; mop = o; end
            end
        end else if (phase == -1 || phase == ITER + 4) begin
            phase = 0;
        end else begin
            phase = phase + 1;
        end
        #1;
        got = {DivMultTempWrite, Mult, Div, DivorMult, WriteHi, WriteLo, Busy, Done, DivZero};
        check("outs", {5'b0, got}, {5'b0, exp_outs(phase, mop)});
        if (Done) done_cnt++;
        if (WriteHi || WriteLo) wr_cnt++;
        if (DivZero) divz_cnt++;
        if (Mult == 2'b10) mstep_cnt++;
        if (Div == 2'b10) dstep_cnt++;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 1'b0; DivisorZero = 1'b0;
        clear_counts();
        step(0, 0, 0, 1);
        step(1, 1, 0, 1);
        check("reset_busy", {15'b0, Busy}, 16'd0);

        // Multiply: full timeline, operand changes while busy ignored.
        clear_counts();
        step(1, 0, 0, 0);
        repeat (ITER + 5) step(0, 1'($urandom), 1'($urandom), 0);
        check("mult_done", 16'(done_cnt), 16'd1);
        check("mult_steps", 16'(mstep_cnt), 16'(ITER));
        check("mult_wr", 16'(wr_cnt), 16'd1);

        // Divide, non-zero divisor.
        clear_counts();
        step(1, 1, 0, 0);
        repeat (ITER + 5) step(0, 1'($urandom), 1'($urandom), 0);
        check("div_done", 16'(done_cnt), 16'd1);
        check("div_steps", 16'(dstep_cnt), 16'(ITER));
        check("div_mult_quiet", 16'(mstep_cnt), 16'd0);

        // Divide by zero.
        clear_counts();
        step(1, 1, 1, 0);
        repeat (3) step(0, 1, 1, 0);
        check("divz_pulse", 16'(divz_cnt), 16'd1);
        check("divz_no_wr", 16'(wr_cnt), 16'd0);
        check("divz_no_done", 16'(done_cnt), 16'd0);

        // Start pulses mid-RUN with Op toggled are ignored.
        clear_counts();
        step(1, 0, 0, 0);
        for (int i = 1; i <= ITER + 5; i++) begin
            step((i == 6 || i == 21), 1, 0, 0);
        end
        check("ign_done", 16'(done_cnt), 16'd1);
        check("ign_mult_steps", 16'(mstep_cnt), 16'(ITER));

        // Reset mid-RUN aborts, then a new op completes in ITER+4 cycles.
        clear_counts();
        step(1, 1, 0, 0);
        repeat (11) step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        check("abort_no_wr", 16'(wr_cnt), 16'd0);
        check("abort_no_done", 16'(done_cnt), 16'd0);
        clear_counts();
        step(1, 0, 0, 0);
        repeat (ITER + 4) step(0, 0, 0, 0);
        check("after_abort_done", 16'(done_cnt), 16'd1);

        // Start held high: back-to-back operations every ITER+5 cycles.
        clear_counts();
        repeat (3 * (ITER + 5)) step(1, 1'($urandom), 0, 0);
        check("b2b_done", 16'(done_cnt), 16'd3);
        check("b2b_wr", 16'(wr_cnt), 16'd3);

        // Random traffic including occasional resets.
        repeat (3000) begin
            step(($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
